// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 encodings, FSM states and size decode for the data-memory unit.
// Build option DMEM_MISALIGNED_SPLIT_EN selects split handling of word-crossing accesses.
package dmem_pkg;

    localparam int LANE_CNT = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
        S_ACC1 = 2'd2,
        S_RESP = 2'd3
    } state_e;

    // Access size in bytes; zero marks an encoding with no legal access.
    function automatic logic [2:0] size_of(input logic [2:0] f3);
        logic [2:0] s;
        case (f3)
            F3_B, F3_BU: s = 3'd1;
            F3_H, F3_HU: s = 3'd2;
            F3_W:        s = 3'd4;
            default:     s = 3'd0;
        endcase
        return s;
    endfunction

    // Plain B/H/W loads sign-extend; the U variants have funct3[2] set.
    function automatic logic is_signed(input logic [2:0] f3);
        return ~f3[2];
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: lane mask, write-data shift and load-byte assembly for one word part.
// part_i=0 covers the addressed word, part_i=1 the spill-over into the next word.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]            off_i,
    input  logic [2:0]            size_i,
    input  logic                  part_i,
    input  logic                  sext_i,
    input  logic [8*LANE_CNT-1:0] wdata_i,
    input  logic [8*LANE_CNT-1:0] rdata_i,
    input  logic [8*LANE_CNT-1:0] asm_i,
    output logic [LANE_CNT-1:0]   mask_o,
    output logic [8*LANE_CNT-1:0] wdata_o,
    output logic [8*LANE_CNT-1:0] asm_o,
    output logic [8*LANE_CNT-1:0] ext_o
);

    logic [LANE_CNT-1:0]   size_mask;
    logic [2*LANE_CNT-1:0] mask_wide;
    logic [5:0]            lo_sh;
    logic [5:0]            hi_sh;

    // Bit shift for the first part, and the complementary shift for the spill part.
    assign lo_sh = {1'b0, off_i, 3'b000};
    assign hi_sh = 6'd32 - lo_sh;

    // Lanes past lane 3 land in the upper half and belong to the next word.
    assign mask_wide = {{LANE_CNT{1'b0}}, size_mask} << off_i;

    // Contiguous lane mask for the access size, starting at lane 0.
    always_comb begin
        size_mask = '0;
        unique case (1'b1)
            size_i == 3'd1: size_mask = 4'b0001;
            size_i == 3'd2: size_mask = 4'b0011;
            size_i == 3'd4: size_mask = 4'b1111;
            default: ;
        endcase
    end

    // Select lanes, shifted store data and assembled load bytes for this part.
    always_comb begin
        if (part_i) begin
            mask_o  = mask_wide[2*LANE_CNT-1:LANE_CNT];
            wdata_o = wdata_i >> hi_sh;
            asm_o   = asm_i | (rdata_i << hi_sh);
        end else begin
            mask_o  = mask_wide[LANE_CNT-1:0];
            wdata_o = wdata_i << lo_sh;
            asm_o   = rdata_i >> lo_sh;
        end
    end

    // Sign- or zero-extend the low bytes of the assembled word.
    always_comb begin
        ext_o = asm_o;
        unique case (1'b1)
            size_i == 3'd1: ext_o = {{24{sext_i & asm_o[7]}}, asm_o[7:0]};
            size_i == 3'd2: ext_o = {{16{sext_i & asm_o[15]}}, asm_o[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: one-at-a-time load/store initiator on a 4-lane byte memory.
// DMEM_MISALIGNED_SPLIT_EN: split word-crossing accesses over two cycles, else flag them.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LANES  = LANE_CNT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LANES-1:0]  mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    state_e            state_q;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       asm_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [31:0]       rsp_rdata_q;

    logic [2:0]        in_size;
    logic              in_err;
    logic [2:0]        acc_size;
    logic              acc_part;

    logic [3:0]        al_mask;
    logic [31:0]       al_wdata;
    logic [31:0]       al_asm;
    logic [31:0]       al_ext;

    assign in_size  = size_of(req_funct3);
    assign acc_size = size_of(f3_q);
    assign acc_part = (state_q == S_ACC1);

`ifdef DMEM_MISALIGNED_SPLIT_EN
    logic              acc_cross;
    logic [ADDR_W-3:0] word_nxt;

    assign in_err    = (in_size == 3'd0);
    assign acc_cross = ({2'b00, addr_q[1:0]} + {1'b0, acc_size}) > 4'd4;
    assign word_nxt  = addr_q[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1};
`else
    logic              in_cross;

    // Without splitting, a crossing access is rejected before touching memory.
    assign in_cross = ({2'b00, req_addr[1:0]} + {1'b0, in_size}) > 4'd4;
    assign in_err   = (in_size == 3'd0) | in_cross;
`endif

    dmem_lane_align u_align (
        .off_i   (addr_q[1:0]),
        .size_i  (acc_size),
        .part_i  (acc_part),
        .sext_i  (is_signed(f3_q)),
        .wdata_i (wdata_q),
        .rdata_i (mem_rdata),
        .asm_i   (asm_q),
        .mask_o  (al_mask),
        .wdata_o (al_wdata),
        .asm_o   (al_asm),
        .ext_o   (al_ext)
    );

    // Memory strobes decode from state so a reset drops them at once.
    always_comb begin
        mem_addr  = '0;
        mem_we    = '0;
        mem_wdata = '0;
        case (state_q)
            S_ACC0: begin
                mem_addr  = addr_q;
                mem_wdata = al_wdata;
                mem_we    = we_q ? al_mask : '0;
            end
`ifdef DMEM_MISALIGNED_SPLIT_EN
            S_ACC1: begin
                mem_addr  = {word_nxt, 2'b00};
                mem_wdata = al_wdata;
                mem_we    = we_q ? al_mask : '0;
            end
`endif
            default: ;
        endcase
    end

    // Request/response FSM with registered handshake and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            f3_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            asm_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        we_q        <= req_we;
                        f3_q        <= req_funct3;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        if (in_err) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            state_q <= S_ACC0;
                        end
                    end
                end
                S_ACC0: begin
                    asm_q <= al_asm;
`ifdef DMEM_MISALIGNED_SPLIT_EN
                    if (acc_cross) begin
                        state_q <= S_ACC1;
                    end else begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= we_q ? '0 : al_ext;
                    end
`else
                    state_q     <= S_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= we_q ? '0 : al_ext;
`endif
                end
`ifdef DMEM_MISALIGNED_SPLIT_EN
                S_ACC1: begin
                    asm_q       <= al_asm;
                    state_q     <= S_RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= we_q ? '0 : al_ext;
                end
`endif
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed and random accesses against a byte-array reference.
// Follows the DMEM_MISALIGNED_SPLIT_EN build setting of the design.
`timescale 1ns/1ps
module tb_dmem_access_unit;

`ifdef DMEM_MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:65535];
    logic [7:0]  ref_mem [0:4095];
    logic [3:0]  cap_we [0:3];
    logic [31:0] cap_addr [0:3];
    logic [31:0] cap_wd [0:3];
    logic [2:0]  f3_tab [0:7];

    int vectors = 0;
    int miscompares = 0;

    dmem_access_unit #(.ADDR_W(32), .LANES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[17:2]];

    // Memory device: commit enabled lanes on the clock edge.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (mem_we[i] === 1'b1)
                mem[mem_addr[17:2]][8*i +: 8] = mem_wdata[8*i +: 8];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int size_bytes(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    // Reference: byte-addressed memory, little-endian, updated on accepted stores.
    task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output logic [31:0] erd,
                         output logic eerr, output int elat, output int elanes);
        int s;
        int off;
        logic [31:0] v;
        s = size_bytes(f3);
        off = int'(addr[1:0]);
        erd = '0;
        eerr = 1'b0;
        elat = 1;
        elanes = 0;
        if (s == 0 || (off + s > 4 && !SPLIT)) begin
            eerr = 1'b1;
        end else begin
            elat = (off + s > 4) ? 3 : 2;
            if (we) begin
                for (int k = 0; k < s; k++) ref_mem[int'(addr) + k] = wd[8*k +: 8];
                elanes = s;
            end else begin
                v = '0;
                for (int k = 0; k < s; k++) v[8*k +: 8] = ref_mem[int'(addr) + k];
                if (!f3[2] && s < 4 && v[8*s-1]) v = v | (32'hFFFF_FFFF << (8*s));
                erd = v;
            end
        end
    endtask

    task automatic xact(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er);
        logic [31:0] erd;
        logic eerr;
        int elat;
        int elanes;
        int lat;
        int lanes;
        int guard;
        bit seen;
        model(we, f3, addr, wd, erd, eerr, elat, elanes);
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we = we;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = '0;
        req_addr = '0;
        req_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            cap_we[i] = '0;
            cap_addr[i] = '0;
            cap_wd[i] = '0;
        end
        lat = 0;
        lanes = 0;
        seen = 1'b0;
        while (!seen && lat < 8) begin
            @(negedge clk);
            if (lat < 4) begin
                cap_we[lat] = mem_we;
                cap_addr[lat] = mem_addr;
                cap_wd[lat] = mem_wdata;
            end
            lat++;
            lanes += $countones(mem_we);
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        check("latency", 32'(lat), 32'(elat));
        check("rsp_err", 32'(rsp_err), 32'(eerr));
        check("rsp_rdata", rsp_rdata, erd);
        rd = rsp_rdata;
        er = rsp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold rsp_rdata", rsp_rdata, erd);
            check("hold rsp_err", 32'(rsp_err), 32'(eerr));
            check("hold req_ready", 32'(req_ready), 32'd0);
            lanes += $countones(mem_we);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("req_ready after rsp", 32'(req_ready), 32'd1);
        check("rsp_valid after rsp", 32'(rsp_valid), 32'd0);
        check("lanes written", 32'(lanes), 32'(elanes));
    endtask

    initial begin
        logic [31:0] rd;
        logic er;
        f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = '0;
        req_addr = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = '0;

        #3;
        check("rst req_ready", 32'(req_ready), 32'd1);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_err", 32'(rsp_err), 32'd0);
        check("rst rsp_rdata", rsp_rdata, 32'd0);
        check("rst mem_we", 32'(mem_we), 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post-rst req_ready", 32'(req_ready), 32'd1);

        xact(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0, rd, er);
        check("sw acc0 mem_we", 32'(cap_we[0]), 32'hF);
        check("sw resp mem_we", 32'(cap_we[1]), 32'h0);
        check("sw acc0 mem_wdata", cap_wd[0], 32'hDEAD_BEEF);
        xact(1'b0, 3'b010, 32'h100, 32'h0, 1, rd, er);
        check("lw word", rd, 32'hDEAD_BEEF);

        mem[4] = 32'h80FF_7F01;
        ref_mem[16] = 8'h01;
        ref_mem[17] = 8'h7F;
        ref_mem[18] = 8'hFF;
        ref_mem[19] = 8'h80;
        xact(1'b0, 3'b000, 32'h13, 32'h0, 0, rd, er);
        check("lb 0x13", rd, 32'hFFFF_FF80);
        xact(1'b0, 3'b100, 32'h13, 32'h0, 0, rd, er);
        check("lbu 0x13", rd, 32'h0000_0080);
        xact(1'b0, 3'b001, 32'h10, 32'h0, 0, rd, er);
        check("lh 0x10", rd, 32'h0000_7F01);
        xact(1'b0, 3'b001, 32'h11, 32'h0, 0, rd, er);
        check("lh 0x11", rd, 32'hFFFF_FF7F);
        xact(1'b0, 3'b101, 32'h12, 32'h0, 0, rd, er);
        check("lhu 0x12", rd, 32'h0000_80FF);

`ifdef DMEM_MISALIGNED_SPLIT_EN
        xact(1'b1, 3'b001, 32'h23, 32'h0000_A55A, 0, rd, er);
        check("sh split acc0 we", 32'(cap_we[0]), 32'h8);
        check("sh split acc0 addr", cap_addr[0], 32'h23);
        check("sh split acc0 lane3", 32'(cap_wd[0][31:24]), 32'h5A);
        check("sh split acc1 we", 32'(cap_we[1]), 32'h1);
        check("sh split acc1 addr", cap_addr[1], 32'h24);
        check("sh split acc1 lane0", 32'(cap_wd[1][7:0]), 32'hA5);
        xact(1'b0, 3'b001, 32'h23, 32'h0, 0, rd, er);
        check("lh split", rd, 32'hFFFF_A55A);
`else
        xact(1'b1, 3'b010, 32'h22, 32'h1122_3344, 0, rd, er);
        check("sw cross err", 32'(er), 32'd1);
        check("sw cross mem_we", 32'(cap_we[0]), 32'h0);
        xact(1'b0, 3'b010, 32'h22, 32'h0, 0, rd, er);
        check("lw cross err", 32'(er), 32'd1);
        check("lw cross rdata", rd, 32'h0);
        xact(1'b0, 3'b010, 32'h20, 32'h0, 0, rd, er);
        check("word 0x20 untouched", rd, 32'h0);
`endif

        xact(1'b0, 3'b011, 32'h40, 32'h0, 5, rd, er);
        check("illegal f3 err", 32'(er), 32'd1);

        req_valid = 1'b1;
        req_we = 1'b1;
        req_funct3 = 3'b010;
        req_addr = SPLIT ? 32'h42 : 32'h40;
        req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = 1'b0;
        check("acc0 we before rst", 32'(mem_we), SPLIT ? 32'hC : 32'hF);
        #2;
        rst = 1'b1;
        #1;
        check("mid rst mem_we", 32'(mem_we), 32'd0);
        check("mid rst req_ready", 32'(req_ready), 32'd1);
        check("mid rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid rst mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        xact(1'b0, 3'b010, 32'h40, 32'h0, 0, rd, er);
        check("word 0x40 after abort", rd, 32'h0);
        xact(1'b0, 3'b010, 32'h44, 32'h0, 0, rd, er);
        check("word 0x44 after abort", rd, 32'h0);

        for (int n = 0; n < 160; n++) begin
            int r;
            logic [2:0] f3;
            r = int'($urandom_range(0, 19));
            f3 = (r < 18) ? f3_tab[r % 5] : f3_tab[5 + int'($urandom_range(0, 2))];
            xact($urandom_range(0, 1) == 1, f3, 32'($urandom_range(0, 1023)),
                 $urandom, int'($urandom_range(0, 2)), rd, er);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
